// File: rtl/util_spi_trans_pkg.sv
// Shared idle levels and select-decode helper for the SPI bus splitter.
package util_spi_trans_pkg;

  localparam logic        CS_IDLE    = 1'b1;
  localparam logic        MOSI_IDLE  = 1'b0;
  localparam int unsigned MAX_SLAVES = 32;
  localparam logic [5:0]  NO_SLAVE   = 6'd32;

  // Returns the lowest index whose active-low select is 0, or NO_SLAVE.
  function automatic logic [5:0] lowest_sel(input logic [MAX_SLAVES-1:0] cs_n);
    logic [5:0] idx;
    idx = NO_SLAVE;
    for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
      if (!cs_n[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/util_spi_trans_lane.sv
// One slave bus: passes chip select through and gates SCLK/MOSI to idle when deselected.
module util_spi_trans_lane
  import util_spi_trans_pkg::*;
#(
  parameter logic CPOL = 1'b0
) (
  input  logic run,
  input  logic cs_eff,
  input  logic m_clk,
  input  logic m_mosi,
  output logic cs,
  output logic sclk,
  output logic mosi
);

  logic sel;

  always_comb begin
    sel  = run & ~cs_eff;
    cs   = run ? cs_eff : CS_IDLE;
    sclk = sel ? m_clk : CPOL;
    mosi = sel ? m_mosi : MOSI_IDLE;
  end

endmodule

// File: rtl/util_spi_trans.sv
// SPI master-to-multi-slave splitter with select-conflict detection.
// Define UTIL_SPI_TRANS_OUTPUT_REG_EN to register cs/sclk/mosi/spi_miso_i (1-cycle latency).
module util_spi_trans
  import util_spi_trans_pkg::*;
#(
  parameter int   SLAVE_NUM = 4,
  parameter logic CPOL      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_mosi_o,
  input  logic                 spi_mosi_t,
  output logic                 spi_mosi_i,
  input  logic                 spi_miso_o,
  input  logic                 spi_miso_t,
  output logic                 spi_miso_i,
  input  logic                 spi_clk_o,
  input  logic                 spi_clk_t,
  output logic                 spi_clk_i,
  input  logic [SLAVE_NUM-1:0] spi_cs_o,
  input  logic                 spi_cs_t,
  output logic [SLAVE_NUM-1:0] spi_cs_i,
  output logic [SLAVE_NUM-1:0] cs,
  output logic [SLAVE_NUM-1:0] sclk,
  output logic [SLAVE_NUM-1:0] mosi,
  input  logic [SLAVE_NUM-1:0] miso,
  output logic                 cs_conflict
);

  logic [SLAVE_NUM-1:0]  cs_eff;
  logic [SLAVE_NUM-1:0]  lane_cs;
  logic [SLAVE_NUM-1:0]  lane_sclk;
  logic [SLAVE_NUM-1:0]  lane_mosi;
  logic [MAX_SLAVES-1:0] cs_pad;
  logic [5:0]            sel_idx;
  logic                  m_clk;
  logic                  m_mosi;
  logic                  miso_sel;
  logic                  run;
  logic                  sel_seen;
  logic                  cs_conflict_d;
  logic                  cs_conflict_q;
  logic                  unused_miso;

  assign unused_miso = spi_miso_o ^ spi_miso_t;

  assign cs_eff = spi_cs_t ? {SLAVE_NUM{1'b1}} : spi_cs_o;
  assign m_clk  = spi_clk_t ? CPOL : spi_clk_o;
  assign m_mosi = spi_mosi_t ? 1'b0 : spi_mosi_o;

`ifdef UTIL_SPI_TRANS_OUTPUT_REG_EN
  // The output registers carry the reset gating, so the lanes always route.
  assign run = 1'b1;
`else
  // Clears asynchronously with rstn and re-arms on the first clk edge after release.
  logic run_d;
  logic run_q;

  always_comb begin
    run_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) run_q <= 1'b0;
    else       run_q <= run_d;
  end

  assign run = run_q;
`endif

  generate
    for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_lane
      util_spi_trans_lane #(
        .CPOL (CPOL)
      ) u_lane (
        .run    (run),
        .cs_eff (cs_eff[gi]),
        .m_clk  (m_clk),
        .m_mosi (m_mosi),
        .cs     (lane_cs[gi]),
        .sclk   (lane_sclk[gi]),
        .mosi   (lane_mosi[gi])
      );
    end
  endgenerate

  // Read-back uses the gated selects so a reset also silences MISO.
  always_comb begin
    cs_pad                  = {MAX_SLAVES{1'b1}};
    cs_pad[SLAVE_NUM-1:0]   = lane_cs;
    sel_idx                 = lowest_sel(cs_pad);
    miso_sel                = 1'b0;
    for (int k = 0; k < SLAVE_NUM; k++) begin
      if (sel_idx == 6'(k)) miso_sel = miso[k];
    end
  end

  always_comb begin
    sel_seen      = 1'b0;
    cs_conflict_d = 1'b0;
    for (int k = 0; k < SLAVE_NUM; k++) begin
      if (!cs_eff[k]) begin
        if (sel_seen) cs_conflict_d = 1'b1;
        sel_seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cs_conflict_q <= 1'b0;
    else       cs_conflict_q <= cs_conflict_d;
  end

  assign cs_conflict = cs_conflict_q;

`ifdef UTIL_SPI_TRANS_OUTPUT_REG_EN
  logic [SLAVE_NUM-1:0] cs_d, cs_q;
  logic [SLAVE_NUM-1:0] sclk_d, sclk_q;
  logic [SLAVE_NUM-1:0] mosi_d, mosi_q;
  logic                 miso_i_d, miso_i_q;

  always_comb begin
    cs_d     = lane_cs;
    sclk_d   = lane_sclk;
    mosi_d   = lane_mosi;
    miso_i_d = miso_sel;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_q     <= {SLAVE_NUM{CS_IDLE}};
      sclk_q   <= {SLAVE_NUM{CPOL}};
      mosi_q   <= {SLAVE_NUM{MOSI_IDLE}};
      miso_i_q <= 1'b0;
    end else begin
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      miso_i_q <= miso_i_d;
    end
  end

  assign cs         = cs_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign spi_miso_i = miso_i_q;
`else
  assign cs         = lane_cs;
  assign sclk       = lane_sclk;
  assign mosi       = lane_mosi;
  assign spi_miso_i = miso_sel;
`endif

  assign spi_cs_i   = cs;
  assign spi_clk_i  = m_clk;
  assign spi_mosi_i = m_mosi;

endmodule

// File: tb/tb_util_spi_trans.sv
// Scoreboard bench for util_spi_trans (SLAVE_NUM=4, CPOL=0); adapts to UTIL_SPI_TRANS_OUTPUT_REG_EN.
module tb_util_spi_trans;

`ifdef UTIL_SPI_TRANS_OUTPUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_mosi_o = 1'b0, spi_mosi_t = 1'b1, spi_mosi_i;
  logic       spi_miso_o = 1'b0, spi_miso_t = 1'b1, spi_miso_i;
  logic       spi_clk_o = 1'b0, spi_clk_t = 1'b1, spi_clk_i;
  logic [3:0] spi_cs_o = 4'hF, spi_cs_i;
  logic       spi_cs_t = 1'b1;
  logic [3:0] cs, sclk, mosi;
  logic [3:0] miso = 4'h0;
  logic       cs_conflict;

  int total = 0;
  int bad   = 0;

  // Packed as {cs, sclk, mosi, spi_miso_i, spi_clk_i, spi_mosi_i}
  logic [14:0] sb[$];
  logic        cf_sb[$];

  always #5 clk = ~clk;

  util_spi_trans #(
    .SLAVE_NUM (4),
    .CPOL      (1'b0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi_mosi_o  (spi_mosi_o),
    .spi_mosi_t  (spi_mosi_t),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .spi_miso_t  (spi_miso_t),
    .spi_miso_i  (spi_miso_i),
    .spi_clk_o   (spi_clk_o),
    .spi_clk_t   (spi_clk_t),
    .spi_clk_i   (spi_clk_i),
    .spi_cs_o    (spi_cs_o),
    .spi_cs_t    (spi_cs_t),
    .spi_cs_i    (spi_cs_i),
    .cs          (cs),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso),
    .cs_conflict (cs_conflict)
  );

  function automatic logic [14:0] obs();
    return {cs, sclk, mosi, spi_miso_i, spi_clk_i, spi_mosi_i};
  endfunction

  // Behavioural reference of the routing for CPOL=0.
  function automatic logic [14:0] model(input logic c_t, input logic [3:0] c_o,
                                        input logic k_t, input logic k_o,
                                        input logic d_t, input logic d_o,
                                        input logic [3:0] mi);
    logic [3:0] e, sc, mo;
    logic       mc, mm, r;
    e  = c_t ? 4'hF : c_o;
    mc = k_t ? 1'b0 : k_o;
    mm = d_t ? 1'b0 : d_o;
    sc = ~e & {4{mc}};
    mo = ~e & {4{mm}};
    r  = 1'b0;
    for (int k = 3; k >= 0; k--) if (!e[k]) r = mi[k];
    return {e, sc, mo, r, mc, mm};
  endfunction

  function automatic logic model_conflict(input logic c_t, input logic [3:0] c_o);
    logic [3:0] e;
    e = c_t ? 4'hF : c_o;
    return $countones(~e) >= 2;
  endfunction

  task automatic apply(input logic c_t, input logic [3:0] c_o, input logic k_t,
                       input logic k_o, input logic d_t, input logic d_o,
                       input logic [3:0] mi);
    spi_cs_t   = c_t;
    spi_cs_o   = c_o;
    spi_clk_t  = k_t;
    spi_clk_o  = k_o;
    spi_mosi_t = d_t;
    spi_mosi_o = d_o;
    miso       = mi;
  endtask

  task automatic settle();
    if (REG_OUT) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [14:0] act, exp;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      apply(1'b0, (i == 0) ? 4'h0 : 4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
      sb.push_back({4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1});
      @(negedge clk);
      act = obs(); exp = sb.pop_front(); total++;
      if (act !== exp) begin
        bad++; $display("FAIL reset_outputs[%0d] got=%h want=%h", i, act, exp);
      end
      total++;
      if (cs_conflict !== 1'b0) begin
        bad++; $display("FAIL reset_conflict[%0d] got=%b want=0", i, cs_conflict);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_cs_tristate();
    logic [14:0] act, exp;
    @(posedge clk); #1;
    apply(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
    sb.push_back({4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1});
    settle();
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL cs_tristate got=%h want=%h", act, exp);
    end
  endtask

  task automatic test_sclk();
    logic [14:0] act, exp;
    logic        t;
    for (int i = 0; i < 4; i++) begin
      t = i[0];
      @(posedge clk); #1;
      apply(1'b0, 4'b1101, t, 1'b1, 1'b1, 1'b0, 4'h0);
      sb.push_back({4'b1101, {2'b00, ~t, 1'b0}, 4'h0, 1'b0, ~t, 1'b0});
      settle();
      act = obs(); exp = sb.pop_front(); total++;
      if (act !== exp) begin
        bad++; $display("FAIL sclk_slave1[%0d] got=%h want=%h", i, act, exp);
      end
    end
  endtask

  task automatic test_mosi();
    logic [14:0] act, exp;
    logic        t;
    for (int i = 0; i < 4; i++) begin
      t = i[0];
      @(posedge clk); #1;
      apply(1'b0, 4'b1011, 1'b1, 1'b0, t, 1'b1, 4'h0);
      sb.push_back({4'b1011, 4'h0, {1'b0, ~t, 2'b00}, 1'b0, 1'b0, ~t});
      settle();
      act = obs(); exp = sb.pop_front(); total++;
      if (act !== exp) begin
        bad++; $display("FAIL mosi_slave2[%0d] got=%h want=%h", i, act, exp);
      end
    end
  endtask

  task automatic test_miso();
    logic [14:0] act, exp;
    logic [3:0]  mi_tab [2];
    logic        want_tab [2];
    mi_tab   = '{4'b1000, 4'b0111};
    want_tab = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply(1'b0, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0, mi_tab[i]);
      sb.push_back({4'b0111, 4'h0, 4'h0, want_tab[i], 1'b0, 1'b0});
      settle();
      act = obs(); exp = sb.pop_front(); total++;
      if (act !== exp) begin
        bad++; $display("FAIL miso_slave3[%0d] got=%h want=%h", i, act, exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic [14:0] act, exp;
    logic        cexp;
    logic [3:0]  cs_tab [5];
    logic [3:0]  mi_tab [5];
    logic        cf_tab [5];
    cs_tab = '{4'b1100, 4'b1100, 4'b1110, 4'b0000, 4'b1111};
    mi_tab = '{4'b0001, 4'b1110, 4'b0001, 4'b1110, 4'b1111};
    cf_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply(1'b0, cs_tab[i], 1'b0, 1'b1, 1'b0, 1'b1, mi_tab[i]);
      sb.push_back(model(1'b0, cs_tab[i], 1'b0, 1'b1, 1'b0, 1'b1, mi_tab[i]));
      cf_sb.push_back(cf_tab[i]);
      settle();
      act = obs(); exp = sb.pop_front(); total++;
      if (act !== exp) begin
        bad++; $display("FAIL conflict_route[%0d] got=%h want=%h", i, act, exp);
      end
      @(posedge clk); @(negedge clk);
      cexp = cf_sb.pop_front(); total++;
      if (cs_conflict !== cexp) begin
        bad++; $display("FAIL cs_conflict[%0d] got=%b want=%b", i, cs_conflict, cexp);
      end
    end
  endtask

  task automatic test_latency();
    logic [14:0] act, exp, old_v, new_v;
    @(posedge clk); #1;
    apply(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    @(posedge clk); @(posedge clk); #1;
    old_v = model(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    new_v = model(1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
    apply(1'b0, 4'b1101, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
    sb.push_back(REG_OUT ? old_v : new_v);
    sb.push_back(new_v);
    @(negedge clk);
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL latency_before_edge got=%h want=%h", act, exp);
    end
    @(posedge clk); #1;
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL latency_after_edge got=%h want=%h", act, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] act, exp, idle_v, live_v;
    @(posedge clk); #1;
    apply(1'b0, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
    live_v = model(1'b0, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
    idle_v = {4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1};
    sb.push_back(live_v);
    sb.push_back(idle_v);
    sb.push_back(idle_v);
    sb.push_back(live_v);
    settle();
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL async_live got=%h want=%h", act, exp);
    end
    #1 rstn = 1'b0;
    #1;
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL async_assert got=%h want=%h", act, exp);
    end
    #1 rstn = 1'b1;
    #1;
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL async_release_wait got=%h want=%h", act, exp);
    end
    @(posedge clk); #1;
    act = obs(); exp = sb.pop_front(); total++;
    if (act !== exp) begin
      bad++; $display("FAIL async_resume got=%h want=%h", act, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] act, exp;
    logic        cexp;
    logic        c_t, k_t, k_o, d_t, d_o;
    logic [3:0]  c_o, mi;
    for (int i = 0; i < 16; i++) begin
      c_t = ($urandom_range(0, 7) == 0);
      c_o = 4'($urandom_range(0, 15));
      k_t = 1'($urandom_range(0, 1));
      k_o = 1'($urandom_range(0, 1));
      d_t = 1'($urandom_range(0, 1));
      d_o = 1'($urandom_range(0, 1));
      mi  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      apply(c_t, c_o, k_t, k_o, d_t, d_o, mi);
      sb.push_back(model(c_t, c_o, k_t, k_o, d_t, d_o, mi));
      cf_sb.push_back(model_conflict(c_t, c_o));
      settle();
      act = obs(); exp = sb.pop_front(); total++;
      if (act !== exp) begin
        bad++; $display("FAIL b2b_route[%0d] got=%h want=%h", i, act, exp);
      end
      @(posedge clk); @(negedge clk);
      cexp = cf_sb.pop_front(); total++;
      if (cs_conflict !== cexp) begin
        bad++; $display("FAIL b2b_conflict[%0d] got=%b want=%b", i, cs_conflict, cexp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cs_tristate();
    test_sclk();
    test_mosi();
    test_miso();
    test_conflict();
    test_latency();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
